// File: rtl/det_stream_ctrl_if.sv
// rtl/det_stream_ctrl_if.sv - word stream handshake bundle between source and det_stream_ctrl
interface det_stream_ctrl_if #(
  parameter int DW = 8
) ();
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/det_stream_ctrl.sv
// rtl/det_stream_ctrl.sv - serialises framed words MSB first into a bit detector and counts its hits
// Optional build macro HIT_SAT_EN: hit counter saturates at all-ones instead of wrapping.
module det_stream_ctrl #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  det_stream_ctrl_if.slave s_if,
  output logic          o_det_in,
  output logic          o_det_rstn,
  input  logic          i_det_hit,
  input  logic [CW-1:0] i_thresh,
  input  logic          i_cnt_clr,
  input  logic          i_irq_clr,
  output logic [CW-1:0] o_hit_cnt,
  output logic          o_irq,
  output logic          o_underrun,
  output logic          o_frame_done,
  output logic          o_busy
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_sr;
  logic [BW-1:0] r_bcnt;
  logic          r_cur_last;
  logic          r_in_frame;
  logic          r_was_shift;
  logic [CW-1:0] r_hit_cnt;
  logic          r_irq;
  logic          r_underrun;

  logic          w_ready;
  logic          w_accept;
  logic          w_last_bit;
  logic          w_stall;
  logic          w_hit;
  logic          w_cnt_en;
  logic          w_counted;
  logic          w_irq_set;
  logic [CW-1:0] w_cnt_next;

  assign w_last_bit = (r_bcnt == LAST_BIT);
  assign w_accept   = s_if.s_valid & w_ready;
  // A non-last word whose final bit finds no follow-up word breaks the frame.
  assign w_stall    = (r_state == SHIFT) & w_last_bit & r_in_frame & ~s_if.s_valid;

  // Next state and per-state outputs toward source and detector.
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    o_det_in     = 1'b0;
    o_det_rstn   = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (s_if.s_valid) w_next = SHIFT;
      end
      SHIFT: begin
        o_det_rstn = 1'b1;
        o_det_in   = r_sr[DW-1];
        w_ready    = w_last_bit & ~r_cur_last;
        if (w_last_bit) w_next = (w_ready & s_if.s_valid) ? SHIFT : DRAIN;
      end
      DRAIN: begin
        o_frame_done = r_cur_last;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign s_if.s_ready = w_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Shift register, bit position and frame tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr        <= '0;
      r_bcnt      <= '0;
      r_cur_last  <= 1'b0;
      r_in_frame  <= 1'b0;
      r_was_shift <= 1'b0;
    end else begin
      r_was_shift <= (r_state == SHIFT);
      if (w_accept) begin
        r_sr       <= s_if.s_data;
        r_bcnt     <= '0;
        r_cur_last <= s_if.s_last;
        r_in_frame <= ~s_if.s_last;
      end else if (r_state == SHIFT) begin
        r_sr   <= {r_sr[DW-2:0], 1'b0};
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // The detector output is registered, so it only reflects a real bit one cycle after SHIFT.
  assign w_hit = r_was_shift & i_det_hit;
`ifdef HIT_SAT_EN
  assign w_cnt_en = w_hit & ~(&r_hit_cnt);
`else
  assign w_cnt_en = w_hit;
`endif
  assign w_cnt_next = i_cnt_clr ? CW'(1) : r_hit_cnt + 1'b1;
  assign w_counted  = i_cnt_clr ? w_hit : w_cnt_en;
  assign w_irq_set  = w_counted & (w_cnt_next == i_thresh) & (i_thresh != '0);

  // Hit counter; a clear coinciding with a hit leaves that hit counted.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_hit_cnt <= '0;
    else if (i_cnt_clr) r_hit_cnt <= {{(CW-1){1'b0}}, w_hit};
    else if (w_cnt_en)  r_hit_cnt <= w_cnt_next;
  end

  // Sticky status flags; a set in the same cycle as irq_clr wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_irq_set)      r_irq <= 1'b1;
      else if (i_irq_clr) r_irq <= 1'b0;
      if (w_stall)        r_underrun <= 1'b1;
      else if (i_irq_clr) r_underrun <= 1'b0;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_irq      = r_irq;
  assign o_underrun = r_underrun;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_det_stream_ctrl.sv
// tb/tb_det_stream_ctrl.sv - self-checking bench for det_stream_ctrl with a behavioural 1011 detector
module tb_det_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        det_in_a, det_rstn_a, thresh_dummy;
  logic        hit_a = 1'b0;
  logic [2:0]  hist_a = 3'b0;
  logic [15:0] thresh;
  logic        cnt_clr, irq_clr;
  logic [15:0] hit_cnt;
  logic        irq, underrun, frame_done, busy;

  logic        det_in_b, det_rstn_b;
  logic        hit_b = 1'b0;
  logic [2:0]  hist_b = 3'b0;
  logic [1:0]  thresh_b;
  logic        cnt_clr_b, irq_clr_b;
  logic [1:0]  hit_cnt_b;
  logic        irq_b, und_b, fd_b, busy_b;

  det_stream_ctrl_if #(.DW(8)) sif ();
  det_stream_ctrl_if #(.DW(8)) sif2 ();

  det_stream_ctrl #(.DW(8), .CW(16)) dut (
    .i_clk(clk), .i_rst(rst), .s_if(sif),
    .o_det_in(det_in_a), .o_det_rstn(det_rstn_a), .i_det_hit(hit_a),
    .i_thresh(thresh), .i_cnt_clr(cnt_clr), .i_irq_clr(irq_clr),
    .o_hit_cnt(hit_cnt), .o_irq(irq), .o_underrun(underrun),
    .o_frame_done(frame_done), .o_busy(busy)
  );

  det_stream_ctrl #(.DW(8), .CW(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .s_if(sif2),
    .o_det_in(det_in_b), .o_det_rstn(det_rstn_b), .i_det_hit(hit_b),
    .i_thresh(thresh_b), .i_cnt_clr(cnt_clr_b), .i_irq_clr(irq_clr_b),
    .o_hit_cnt(hit_cnt_b), .o_irq(irq_b), .o_underrun(und_b),
    .o_frame_done(fd_b), .o_busy(busy_b)
  );

  // Overlapping 1011 detectors with registered output and sync active-low clear.
  always @(posedge clk) begin
    if (!det_rstn_a) begin hist_a <= 3'b0; hit_a <= 1'b0; end
    else begin hit_a <= ({hist_a, det_in_a} == 4'b1011); hist_a <= {hist_a[1:0], det_in_a}; end
    if (!det_rstn_b) begin hist_b <= 3'b0; hit_b <= 1'b0; end
    else begin hit_b <= ({hist_b, det_in_b} == 4'b1011); hist_b <= {hist_b[1:0], det_in_b}; end
  end

  // Monitors: serial bits seen by the detector and frame_done pulses.
  bit obs_bits[$];
  int fd_total = 0;
  always @(negedge clk) begin
    if (!rst && det_rstn_a) obs_bits.push_back(det_in_a);
    if (!rst && frame_done) fd_total++;
  end

  int n_chk = 0;
  int n_fail = 0;
  bit exp_bits[$];
  bit seg[$];
  int exp_hits;

  typedef struct {
    int          n;
    logic [7:0]  d0, d1;
    logic        l0, l1;
    int          gap;
    logic [15:0] th;
    logic [15:0] e_cnt;
    logic        e_und;
    logic        e_irq;
    int          e_fd;
  } vec_t;
  vec_t vt[8];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    int   t;
    sif.s_valid = 1'b1; sif.s_data = d; sif.s_last = l;
    t = 0;
    do begin acc = sif.s_ready; step(); t++; end while (!acc && t < 50);
    sif.s_valid = 1'b0;
    check("send_accept", {31'b0, acc}, 32'd1);
    for (int i = 7; i >= 0; i--) begin exp_bits.push_back(d[i]); seg.push_back(d[i]); end
  endtask

  // Counts overlapping 1011 patterns in one uninterrupted detector segment.
  function automatic void end_segment();
    for (int i = 3; i < seg.size(); i++)
      if (seg[i-3] == 1 && seg[i-2] == 0 && seg[i-1] == 1 && seg[i] == 1) exp_hits++;
    seg.delete();
  endfunction

  task automatic clr_all();
    cnt_clr = 1'b1; irq_clr = 1'b1; step(); cnt_clr = 1'b0; irq_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] pat, d;
    logic       l, acc;
    int         fd0, obs0, bad, th, exp_fd, t;
    logic       exp_und;

    vt[0] = '{1, 8'hB0, 8'h00, 1'b1, 1'b0, 0, 16'd0, 16'd1, 1'b0, 1'b0, 1};
    vt[1] = '{2, 8'h05, 8'h80, 1'b0, 1'b1, 0, 16'd0, 16'd1, 1'b0, 1'b0, 1};
    vt[2] = '{2, 8'h05, 8'h80, 1'b1, 1'b1, 0, 16'd0, 16'd0, 1'b0, 1'b0, 2};
    vt[3] = '{2, 8'h05, 8'h80, 1'b0, 1'b1, 3, 16'd0, 16'd0, 1'b1, 1'b0, 1};
    vt[4] = '{1, 8'hBB, 8'h00, 1'b1, 1'b0, 0, 16'd2, 16'd2, 1'b0, 1'b1, 1};
    vt[5] = '{1, 8'hBB, 8'h00, 1'b1, 1'b0, 0, 16'd3, 16'd2, 1'b0, 1'b0, 1};
    vt[6] = '{2, 8'h2D, 8'h60, 1'b0, 1'b1, 0, 16'd0, 16'd2, 1'b0, 1'b0, 1};
    vt[7] = '{2, 8'h2D, 8'h60, 1'b0, 1'b1, 1, 16'd0, 16'd1, 1'b1, 1'b0, 1};

    rst = 1'b1; thresh = 16'd0; cnt_clr = 1'b0; irq_clr = 1'b0; thresh_dummy = 1'b0;
    thresh_b = 2'd0; cnt_clr_b = 1'b0; irq_clr_b = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_last = 1'b0;
    sif2.s_valid = 1'b0; sif2.s_data = 8'h00; sif2.s_last = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    check("rst_flags", {27'b0, irq, underrun, frame_done, busy, det_rstn_a}, 32'd0);
    check("rst_det_in", {31'b0, det_in_a}, 32'd0);
    check("rst_ready", {31'b0, sif.s_ready}, 32'd1);

    // Narrow counter: four single-hit frames.
    for (int f = 0; f < 4; f++) begin
      sif2.s_valid = 1'b1; sif2.s_data = 8'hB0; sif2.s_last = 1'b1;
      t = 0;
      do begin acc = sif2.s_ready; step(); t++; end while (!acc && t < 50);
      sif2.s_valid = 1'b0;
      check("cw2_accept", {31'b0, acc}, 32'd1);
      repeat (12) step();
      if (f == 2) check("cw2_cnt3", {30'b0, hit_cnt_b}, 32'd3);
    end
`ifdef HIT_SAT_EN
    check("cw2_cnt_final", {30'b0, hit_cnt_b}, 32'd3);
`else
    check("cw2_cnt_final", {30'b0, hit_cnt_b}, 32'd0);
`endif
    check("cw2_idle", {28'b0, irq_b, und_b, fd_b, busy_b}, 32'd0);

    // Bit order and frame_done timing for a single-word frame.
    clr_all();
    pat = 8'hB0;
    send(pat, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("det_in_bit", {31'b0, det_in_a}, {31'b0, pat[7-k]});
      check("det_rstn_shift", {31'b0, det_rstn_a}, 32'd1);
      step();
    end
    check("frame_done_pulse", {30'b0, frame_done, det_rstn_a}, 32'd2);
    step();
    check("frame_done_end", {30'b0, frame_done, busy}, 32'd0);
    repeat (4) step();
    check("t1_hit_cnt", {16'b0, hit_cnt}, 32'd1);

    // Ready window only in the final bit cycle of a non-last word.
    clr_all();
    send(8'h05, 1'b0);
    check("ready_bit0", {31'b0, sif.s_ready}, 32'd0);
    repeat (6) step();
    check("ready_bit6", {31'b0, sif.s_ready}, 32'd0);
    step();
    check("ready_bit7", {31'b0, sif.s_ready}, 32'd1);
    send(8'h80, 1'b1);
    repeat (12) step();
    check("b2b_hit_cnt", {16'b0, hit_cnt}, 32'd1);
    check("b2b_underrun", {31'b0, underrun}, 32'd0);

    // Table of short frames.
    for (int v = 0; v < 8; v++) begin
      thresh = vt[v].th;
      clr_all();
      fd0 = fd_total;
      send(vt[v].d0, vt[v].l0);
      if (vt[v].n == 2) begin
        if (vt[v].gap != 0) repeat (8 + vt[v].gap) step();
        send(vt[v].d1, vt[v].l1);
      end
      repeat (12) step();
      check($sformatf("vec%0d_hit_cnt", v), {16'b0, hit_cnt}, {16'b0, vt[v].e_cnt});
      check($sformatf("vec%0d_underrun", v), {31'b0, underrun}, {31'b0, vt[v].e_und});
      check($sformatf("vec%0d_irq", v), {31'b0, irq}, {31'b0, vt[v].e_irq});
      check($sformatf("vec%0d_frame_done", v), fd_total - fd0, vt[v].e_fd);
      irq_clr = 1'b1; step(); irq_clr = 1'b0;
      check($sformatf("vec%0d_irq_clr", v), {30'b0, irq, underrun}, 32'd0);
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      check($sformatf("vec%0d_cnt_clr", v), {16'b0, hit_cnt}, 32'd0);
    end

    // cnt_clr in the very cycle a hit is sampled leaves the count at 1.
    thresh = 16'd0;
    clr_all();
    send(8'hB0, 1'b1);
    repeat (12) step();
    send(8'hB0, 1'b1);
    repeat (4) step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check("clr_with_hit", {16'b0, hit_cnt}, 32'd1);
    repeat (8) step();

    // irq set and irq_clr together: set wins; thresh change alone never sets irq.
    clr_all();
    thresh = 16'd1;
    send(8'hB0, 1'b1);
    repeat (4) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("irq_set_wins", {31'b0, irq}, 32'd1);
    repeat (8) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("irq_cleared", {31'b0, irq}, 32'd0);
    thresh = 16'd5; step(); thresh = 16'd1; repeat (3) step();
    check("thresh_change_no_irq", {31'b0, irq}, 32'd0);

    // Stall and irq_clr together: underrun set wins.
    send(8'h05, 1'b0);
    repeat (7) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("underrun_set_wins", {31'b0, underrun}, 32'd1);
    step();
    check("stall_idle", {30'b0, busy, frame_done}, 32'd0);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("underrun_cleared", {31'b0, underrun}, 32'd0);
    send(8'h00, 1'b1);
    repeat (12) step();

    // Randomised frames against the pattern-count model.
    seg.delete(); exp_bits.delete();
    obs0 = obs_bits.size(); fd0 = fd_total;
    exp_hits = 0; exp_und = 1'b0; exp_fd = 0;
    th = $urandom_range(1, 8);
    thresh = 16'(th);
    clr_all();
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      l = (i == 39) || ($urandom_range(0, 3) == 0);
      send(d, l);
      if (l) begin
        end_segment(); exp_fd++;
        repeat ($urandom_range(0, 3)) step();
      end else if ($urandom_range(0, 3) == 0) begin
        repeat (8 + $urandom_range(1, 3)) step();
        end_segment(); exp_und = 1'b1;
      end
    end
    repeat (12) step();
    check("rnd_hit_cnt", {16'b0, hit_cnt}, {16'b0, 16'(exp_hits)});
    check("rnd_underrun", {31'b0, underrun}, {31'b0, exp_und});
    check("rnd_irq", {31'b0, irq}, {31'b0, exp_hits >= th});
    check("rnd_frame_done", fd_total - fd0, exp_fd);
    check("rnd_bits_size", obs_bits.size() - obs0, exp_bits.size());
    bad = 0;
    for (int i = 0; i < exp_bits.size() && obs0 + i < obs_bits.size(); i++)
      if (obs_bits[obs0 + i] !== exp_bits[i]) bad++;
    check("rnd_bits_match", bad, 0);

    // Reset in the middle of a resumed word.
    thresh = 16'd0;
    send(8'h05, 1'b0);
    repeat (10) step();
    send(8'hB0, 1'b0);
    repeat (5) step();
    check("pre_rst_state", {30'b0, underrun, busy}, 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    fd0 = fd_total;
    check("mid_rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    check("mid_rst_flags", {27'b0, irq, underrun, frame_done, busy, det_rstn_a}, 32'd0);
    check("mid_rst_ready", {30'b0, sif.s_ready, det_in_a}, 32'd2);
    repeat (15) step();
    check("mid_rst_no_frame_done", fd_total - fd0, 0);
    check("mid_rst_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
